debug_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one slave port of the simple wreq/wgnt/rreq/rgnt debug bus among N masters, e.g. a debug UART and user logic both accessing one RAM or register file. It serves one transaction, read or write, at a time, and latches address and data when it selects a transaction. It passes grants through combinationally so that masters using either rdata capture mode work unchanged. It also handles abandoned transactions, i.e. masters that time out and drop their request.

---
 rtl/debug_bus_pkg.sv | 12 +
 rtl/debug_rr_pick.sv | 21 ++
 rtl/debug_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_debug_bus_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/debug_bus_pkg.sv
// Shared types and helpers for the debug bus arbiter and its round-robin picker.
package debug_bus_pkg;

    typedef enum logic {IDLE = 1'b0, SLAVE = 1'b1} state_e;
    typedef enum logic {KIND_W = 1'b0, KIND_R = 1'b1} kind_e;

    // Round-robin pointer one past the current owner, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/debug_rr_pick.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping.
module debug_rr_pick #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
        end
    end

endmodule

// File: rtl/debug_bus_arbiter.sv
// Round-robin arbiter sharing one wreq/wgnt/rreq/rgnt debug slave among N_MST masters,
// one transaction at a time, with abandoned-request handling.
import debug_bus_pkg::*;

module debug_bus_arbiter #(
    parameter  int N_MST           = 2,
    parameter  int ADDR_BYTE_WIDTH = 4,
    parameter  int DATA_BYTE_WIDTH = 4,
    localparam int AW              = 8 * ADDR_BYTE_WIDTH,
    localparam int DW              = 8 * DATA_BYTE_WIDTH,
    localparam int IW              = (N_MST > 1) ? $clog2(N_MST) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_MST-1:0]    m_wreq,
    input  logic [N_MST*AW-1:0] m_waddr,
    input  logic [N_MST*DW-1:0] m_wdata,
    output logic [N_MST-1:0]    m_wgnt,
    input  logic [N_MST-1:0]    m_rreq,
    input  logic [N_MST*AW-1:0] m_raddr,
    output logic [N_MST-1:0]    m_rgnt,
    output logic [DW-1:0]       m_rdata,
    output logic                s_wreq,
    output logic [AW-1:0]       s_waddr,
    output logic [DW-1:0]       s_wdata,
    input  logic                s_wgnt,
    output logic                s_rreq,
    output logic [AW-1:0]       s_raddr,
    input  logic                s_rgnt,
    input  logic [DW-1:0]       s_rdata,
    output logic [IW-1:0]       owner,
    output logic                busy
);

    state_e        state_q, state_d;
    kind_e         kind_q, kind_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          s_wreq_q, s_wreq_d;
    logic          s_rreq_q, s_rreq_d;
    logic [AW-1:0] s_waddr_q, s_waddr_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d;
    logic [AW-1:0] s_raddr_q, s_raddr_d;

    logic [N_MST-1:0] cand;
    logic             pick_vld;
    logic [IW-1:0]    pick_idx;
    logic             slv_gnt;
    logic             own_req;

    assign cand = m_wreq | m_rreq;

    debug_rr_pick #(.N(N_MST)) u_pick (
        .req   (cand),
        .ptr   (rr_ptr_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign slv_gnt = (kind_q == KIND_W) ? s_wgnt : s_rgnt;
    assign own_req = (kind_q == KIND_W) ? m_wreq[owner_q] : m_rreq[owner_q];

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        s_wreq_d  = s_wreq_q;
        s_rreq_d  = s_rreq_q;
        s_waddr_d = s_waddr_q;
        s_wdata_d = s_wdata_q;
        s_raddr_d = s_raddr_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = SLAVE;
                    owner_d = pick_idx;
                    // Write takes precedence when a master raises both requests.
                    if (m_wreq[pick_idx]) begin
                        kind_d    = KIND_W;
                        s_wreq_d  = 1'b1;
                        s_waddr_d = m_waddr[int'(pick_idx)*AW +: AW];
                        s_wdata_d = m_wdata[int'(pick_idx)*DW +: DW];
                    end else begin
                        kind_d    = KIND_R;
                        s_rreq_d  = 1'b1;
                        s_raddr_d = m_raddr[int'(pick_idx)*AW +: AW];
                    end
                end
            end
            SLAVE: begin
                // A grant completes the transfer even if the owner drops req in the same cycle.
                if (slv_gnt || !own_req) begin
                    state_d  = IDLE;
                    s_wreq_d = 1'b0;
                    s_rreq_d = 1'b0;
                    rr_ptr_d = IW'(rr_next(32'(owner_q), N_MST));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            kind_q    <= KIND_W;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            s_wreq_q  <= 1'b0;
            s_rreq_q  <= 1'b0;
            s_waddr_q <= '0;
            s_wdata_q <= '0;
            s_raddr_q <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            s_wreq_q  <= s_wreq_d;
            s_rreq_q  <= s_rreq_d;
            s_waddr_q <= s_waddr_d;
            s_wdata_q <= s_wdata_d;
            s_raddr_q <= s_raddr_d;
        end
    end

    always_comb begin
        m_wgnt = '0;
        m_rgnt = '0;
        if (state_q == SLAVE) begin
            if (kind_q == KIND_W) m_wgnt[owner_q] = s_wgnt;
            else                  m_rgnt[owner_q] = s_rgnt;
        end
    end

    assign m_rdata = s_rdata;
    assign s_wreq  = s_wreq_q;
    assign s_rreq  = s_rreq_q;
    assign s_waddr = s_waddr_q;
    assign s_wdata = s_wdata_q;
    assign s_raddr = s_raddr_q;
    assign owner   = owner_q;
    assign busy    = s_wreq_q | s_rreq_q;

endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Directed bench for debug_bus_arbiter with two masters and a hand-driven slave.
module tb_debug_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk, rst_n;
    logic [N-1:0]    m_wreq, m_rreq, m_wgnt, m_rgnt;
    logic [N*AW-1:0] m_waddr, m_raddr;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            s_wreq, s_rreq, s_wgnt, s_rgnt;
    logic [AW-1:0]   s_waddr, s_raddr;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [0:0]      owner;
    logic            busy;

    int n_chk = 0;
    int n_err = 0;

    debug_bus_arbiter #(.N_MST(N), .ADDR_BYTE_WIDTH(4), .DATA_BYTE_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_wreq(m_wreq), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wgnt(m_wgnt),
        .m_rreq(m_rreq), .m_raddr(m_raddr), .m_rgnt(m_rgnt), .m_rdata(m_rdata),
        .s_wreq(s_wreq), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wgnt(s_wgnt),
        .s_rreq(s_rreq), .s_raddr(s_raddr), .s_rgnt(s_rgnt), .s_rdata(s_rdata),
        .owner(owner), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        m_wreq = '0; m_rreq = '0; m_waddr = '0; m_raddr = '0; m_wdata = '0;
        s_wgnt = 1'b0; s_rgnt = 1'b0; s_rdata = '0;

        // Reset state
        cyc(); cyc(); settle();
        chk("rst_busy",   64'(busy),    64'h0);
        chk("rst_owner",  64'(owner),   64'h0);
        chk("rst_s_wreq", 64'(s_wreq),  64'h0);
        chk("rst_s_rreq", 64'(s_rreq),  64'h0);
        chk("rst_gnts",   64'({m_wgnt, m_rgnt}), 64'h0);
        chk("rst_addr",   64'({s_waddr, s_raddr}), 64'h0);
        cyc(); rst_n = 1'b1;

        // Master 1 read of 0x10, slave grants 3 cycles after s_rreq rises
        cyc(); m_rreq[1] = 1'b1; m_raddr[AW +: AW] = 32'h10; settle();
        chk("rd_c0_idle", 64'(s_rreq), 64'h0);
        cyc(); settle();
        chk("rd_c1_sreq",  64'(s_rreq),  64'h1);
        chk("rd_c1_raddr", 64'(s_raddr), 64'h10);
        chk("rd_c1_owner", 64'(owner),   64'h1);
        chk("rd_c1_busy",  64'(busy),    64'h1);
        chk("rd_c1_nogn",  64'(m_rgnt),  64'h0);
        cyc(); cyc(); settle();
        chk("rd_c3_sreq", 64'(s_rreq), 64'h1);
        cyc(); s_rgnt = 1'b1; s_rdata = 32'hDEADBEEF; settle();
        chk("rd_c4_rgnt",  64'(m_rgnt),  64'h2);
        chk("rd_c4_rdata", 64'(m_rdata), 64'hDEADBEEF);
        chk("rd_c4_wgnt",  64'(m_wgnt),  64'h0);
        cyc(); s_rgnt = 1'b0; m_rreq[1] = 1'b0; settle();
        chk("rd_c5_sreq", 64'(s_rreq), 64'h0);
        chk("rd_c5_busy", 64'(busy),   64'h0);
        chk("rd_c5_gnt",  64'(m_rgnt), 64'h0);

        // m0 write 0x4=0x1234 and m1 read both held: owners alternate 0,1,0,1
        cyc();
        m_wreq[0] = 1'b1; m_waddr[0 +: AW] = 32'h4; m_wdata[0 +: DW] = 32'h1234;
        m_rreq[1] = 1'b1; m_raddr[AW +: AW] = 32'h20;
        for (int t = 0; t < 4; t++) begin
            cyc();
            if (t % 2 == 0) s_wgnt = 1'b1; else s_rgnt = 1'b1;
            settle();
            chk("alt_owner", 64'(owner), 64'(t % 2));
            chk("alt_busy",  64'(busy),  64'h1);
            if (t % 2 == 0) begin
                chk("alt_wgnt",  64'({m_wgnt, m_rgnt}), 64'h4);
                chk("alt_waddr", 64'(s_waddr), 64'h4);
                chk("alt_wdata", 64'(s_wdata), 64'h1234);
            end else begin
                chk("alt_rgnt",  64'({m_wgnt, m_rgnt}), 64'h2);
                chk("alt_raddr", 64'(s_raddr), 64'h20);
            end
            cyc(); s_wgnt = 1'b0; s_rgnt = 1'b0;
            if (t == 3) begin m_wreq = '0; m_rreq = '0; end
            settle();
            chk("alt_idle", 64'(busy), 64'h0);
        end

        // m0 raises wreq and rreq together: write first, then read
        cyc();
        m_wreq[0] = 1'b1; m_rreq[0] = 1'b1; m_waddr[0 +: AW] = 32'h30; m_raddr[0 +: AW] = 32'h40;
        cyc(); s_wgnt = 1'b1; settle();
        chk("wr_first_sw", 64'({s_wreq, s_rreq}), 64'h2);
        chk("wr_first_ow", 64'(owner), 64'h0);
        chk("wr_first_g",  64'({m_wgnt, m_rgnt}), 64'h4);
        cyc(); s_wgnt = 1'b0; m_wreq[0] = 1'b0; settle();
        chk("wr_done_idle", 64'(busy), 64'h0);
        cyc(); s_rgnt = 1'b1; settle();
        chk("rd_second_sr", 64'({s_wreq, s_rreq}), 64'h1);
        chk("rd_second_ad", 64'(s_raddr), 64'h40);
        chk("rd_second_ow", 64'(owner), 64'h0);
        chk("rd_second_g",  64'({m_wgnt, m_rgnt}), 64'h1);
        cyc(); s_rgnt = 1'b0; m_rreq[0] = 1'b0; settle();
        chk("rd_done_idle", 64'(busy), 64'h0);

        // Abort: slave never grants, m1 drops rreq after 200 cycles
        cyc(); m_rreq[1] = 1'b1; m_raddr[AW +: AW] = 32'h50;
        cyc(); settle();
        chk("ab_start", 64'(s_rreq), 64'h1);
        repeat (199) cyc();
        settle();
        chk("ab_hold",  64'({s_rreq, m_rgnt}), 64'h4);
        cyc(); m_rreq[1] = 1'b0; settle();
        chk("ab_drop_cycle", 64'({s_rreq, m_rgnt}), 64'h4);
        cyc(); m_wreq = 2'b11; m_waddr = {32'h74, 32'h70}; settle();
        chk("ab_sreq_low", 64'(s_rreq), 64'h0);
        chk("ab_busy",     64'(busy),   64'h0);
        chk("ab_no_gnt",   64'(m_rgnt), 64'h0);
        // Pointer returned to 0: m0 wins over m1
        cyc(); s_wgnt = 1'b1; settle();
        chk("ab_ptr_owner", 64'(owner),   64'h0);
        chk("ab_ptr_addr",  64'(s_waddr), 64'h70);
        chk("ab_ptr_gnt",   64'(m_wgnt),  64'h1);
        cyc(); s_wgnt = 1'b0; m_wreq[0] = 1'b0;
        cyc(); s_wgnt = 1'b1; settle();
        chk("ab_next_owner", 64'(owner),  64'h1);
        chk("ab_next_gnt",   64'(m_wgnt), 64'h2);
        cyc(); s_wgnt = 1'b0; m_wreq = '0;

        // Reset pulse during SLAVE with s_wgnt high
        cyc(); m_wreq[0] = 1'b1; m_waddr[0 +: AW] = 32'h60; m_wdata[0 +: DW] = 32'h55;
        cyc(); settle();
        chk("rs_sreq", 64'(s_wreq), 64'h1);
        s_wgnt = 1'b1; rst_n = 1'b0; #1;
        chk("rs_sreq_clr", 64'({s_wreq, s_rreq}), 64'h0);
        chk("rs_busy",     64'(busy), 64'h0);
        chk("rs_nogn",     64'({m_wgnt, m_rgnt}), 64'h0);
        chk("rs_addr",     64'(s_waddr), 64'h0);
        chk("rs_owner",    64'(owner), 64'h0);
        cyc(); rst_n = 1'b1; s_wgnt = 1'b0; settle();
        chk("rs_idle", 64'(busy), 64'h0);
        cyc(); s_wgnt = 1'b1; settle();
        chk("rs_again_addr", 64'(s_waddr), 64'h60);
        chk("rs_again_data", 64'(s_wdata), 64'h55);
        chk("rs_again_gnt",  64'(m_wgnt),  64'h1);
        cyc(); s_wgnt = 1'b0; m_wreq = '0;

        // Address change while pending is ignored
        cyc(); m_wreq[0] = 1'b1; m_waddr[0 +: AW] = 32'h8;
        cyc(); m_waddr[0 +: AW] = 32'hC; settle();
        chk("hold_c1", 64'(s_waddr), 64'h8);
        cyc(); settle();
        chk("hold_c2", 64'(s_waddr), 64'h8);
        cyc(); s_wgnt = 1'b1; settle();
        chk("hold_gnt_addr", 64'(s_waddr), 64'h8);
        chk("hold_gnt",      64'(m_wgnt),  64'h1);
        cyc(); s_wgnt = 1'b0; m_wreq = '0; settle();
        chk("hold_idle", 64'(busy), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
